// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU writeback constants and helpers for the register-file
// writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int ADDR_W               = 5;
    localparam int DATA_W               = 32;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    // Which requester owns the write port on a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LSU  = 2'd2
    } wb_sel_e;

    // Register x0 is hardwired, so a write to it is accepted but never issued.
    function automatic logic addr_writes(input logic [ADDR_W-1:0] addr);
        return (addr != {ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_grant.sv
// Writeback grant logic: LSU has priority, but an ALU that has lost
// STARVE_LIMIT consecutive contended cycles is forced to win.
module wb_grant
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic lsu_valid,
    output logic alu_grant,
    output logic lsu_grant
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             at_limit_s;

    // Grant decision: reset blocks both, lone requesters win at once.
    always_comb begin
        at_limit_s = (starve_cnt_r == LIMIT_C);
        alu_grant  = 1'b0;
        lsu_grant  = 1'b0;
        if (rst) begin
            alu_grant = 1'b0;
            lsu_grant = 1'b0;
        end else if (alu_valid && (!lsu_valid || at_limit_s)) begin
            alu_grant = 1'b1;
        end else if (lsu_valid) begin
            lsu_grant = 1'b1;
        end else begin
            alu_grant = 1'b0;
            lsu_grant = 1'b0;
        end
    end

    // Starvation counter: counts ALU losses, saturates, clears on win or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!alu_valid || alu_grant) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!at_limit_s) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and LSU writeback requests
// onto a single registered write port with one cycle of latency.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_waddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] pend_addr,
    output logic              pend_valid
);

    logic              alu_grant_s;
    logic              lsu_grant_s;
    wb_sel_e           sel_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_data_s;

    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_waddr_r;
    logic [DATA_W-1:0] rf_wdata_r;

    wb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .lsu_valid (lsu_valid),
        .alu_grant (alu_grant_s),
        .lsu_grant (lsu_grant_s)
    );

    assign alu_ready = alu_grant_s;
    assign lsu_ready = lsu_grant_s;

    // Select the winning request's address and data.
    always_comb begin
        sel_s      = SEL_NONE;
        win_addr_s = {ADDR_W{1'b0}};
        win_data_s = {DATA_W{1'b0}};
        if (alu_grant_s) begin
            sel_s      = SEL_ALU;
            win_addr_s = alu_waddr;
            win_data_s = alu_wdata;
        end else if (lsu_grant_s) begin
            sel_s      = SEL_LSU;
            win_addr_s = lsu_waddr;
            win_data_s = lsu_wdata;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Write-port register: capture a transfer, pulse we, hold data when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {ADDR_W{1'b0}};
            rf_wdata_r <= {DATA_W{1'b0}};
        end else begin
            case (sel_s)
                SEL_ALU, SEL_LSU: begin
                    rf_we_r    <= addr_writes(win_addr_s);
                    rf_waddr_r <= win_addr_s;
                    rf_wdata_r <= win_data_s;
                end
                default: begin
                    rf_we_r    <= 1'b0;
                    rf_waddr_r <= rf_waddr_r;
                    rf_wdata_r <= rf_wdata_r;
                end
            endcase
        end
    end

    assign rf_we      = rf_we_r;
    assign rf_waddr   = rf_waddr_r;
    assign rf_wdata   = rf_wdata_r;
    assign pend_addr  = rf_waddr_r;
    assign pend_valid = rf_we_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, compared against a behavioural arbitration model.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  pend_addr;
    logic        pend_valid;

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        exp_alu;
    logic        exp_lsu;
    logic        obs_alu;
    logic        obs_lsu;
    logic [31:0] rf_obs [32];

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_waddr  (alu_waddr),
        .alu_wdata  (alu_wdata),
        .alu_ready  (alu_ready),
        .lsu_valid  (lsu_valid),
        .lsu_waddr  (lsu_waddr),
        .lsu_wdata  (lsu_wdata),
        .lsu_ready  (lsu_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pend_addr  (pend_addr),
        .pend_valid (pend_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock cycle: drive, check readys before the edge, advance the model,
    // check the write port after the edge.
    task automatic do_cycle(input logic r,
                            input logic av, input logic [4:0] aa, input logic [31:0] ad,
                            input logic lv, input logic [4:0] la, input logic [31:0] ld);
        rst = r;
        alu_valid = av; alu_waddr = aa; alu_wdata = ad;
        lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
        #1;
        exp_alu = !r && av && (!lv || m_starve >= LIMIT);
        exp_lsu = !r && lv && !exp_alu;
        obs_alu = alu_ready;
        obs_lsu = lsu_ready;
        check("alu_ready", {31'd0, alu_ready}, {31'd0, exp_alu});
        check("lsu_ready", {31'd0, lsu_ready}, {31'd0, exp_lsu});
        @(posedge clk);
        if (r) begin
            m_starve = 0; m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        end else begin
            if (exp_alu) begin
                m_we = (aa != 5'd0); m_waddr = aa; m_wdata = ad;
            end else if (exp_lsu) begin
                m_we = (la != 5'd0); m_waddr = la; m_wdata = ld;
            end else begin
                m_we = 1'b0;
            end
            if (!av || exp_alu) m_starve = 0;
            else if (m_starve < LIMIT) m_starve = m_starve + 1;
        end
        #1;
        check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
        check("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
        check("rf_wdata", rf_wdata, m_wdata);
        check("pend_addr", {27'd0, pend_addr}, {27'd0, m_waddr});
        check("pend_valid", {31'd0, pend_valid}, {31'd0, m_we});
        if (rf_we === 1'b1) rf_obs[rf_waddr] = rf_wdata;
        @(negedge clk);
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic [4:0]  ha, hl;
        logic [31:0] hd, hm;
        logic        hav, hlv;
        int          alu_wins;

        for (int i = 0; i < 32; i++) rf_obs[i] = 32'd0;
        m_starve = 0; m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;

        // Reset with both requesters valid: no grants, outputs cleared.
        do_cycle(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        do_cycle(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        check("reset_rf_we", {31'd0, rf_we}, 32'd0);
        check("reset_rf_wdata", rf_wdata, 32'd0);
        idle();

        // Lone ALU write.
        do_cycle(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        check("lone_alu_ready", {31'd0, obs_alu}, 32'd1);
        check("lone_alu_data", rf_wdata, 32'h1234);
        check("lone_alu_addr", {27'd0, rf_waddr}, 32'd5);
        idle();
        check("hold_wdata", rf_wdata, 32'h1234);

        // Contention: LSU four times, then ALU, repeating.
        ha = 5'd9; hd = 32'hA000;
        alu_wins = 0;
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b0, 1'b1, ha, hd, 1'b1, 5'(10 + i), 32'hB000 + 32'(i));
            check("contention_pattern", {31'd0, obs_alu}, {31'd0, (i % 5) == 4});
            if (obs_alu) begin
                alu_wins++;
                hd = hd + 32'd1;
            end
        end
        check("contention_alu_wins", alu_wins, 32'd2);
        idle();

        // Write to x0 is accepted but never issued.
        do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
        check("x0_lsu_ready", {31'd0, obs_lsu}, 32'd1);
        check("x0_rf_we", {31'd0, rf_we}, 32'd0);
        check("x0_pend_valid", {31'd0, pend_valid}, 32'd0);

        // Same-address collision: LSU first, then ALU; ALU data survives.
        do_cycle(1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        check("collide_first", rf_wdata, 32'hB);
        do_cycle(1'b0, 1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 32'd0);
        check("collide_second", rf_wdata, 32'hA);
        idle();
        check("collide_final", rf_obs[7], 32'hA);

        // Reset right after an LSU transfer discards the pending write.
        do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hCAFE);
        do_cycle(1'b1, 1'b1, 5'd13, 32'hBEEF, 1'b1, 5'd14, 32'hF00D);
        check("midreset_alu_ready", {31'd0, obs_alu}, 32'd0);
        check("midreset_lsu_ready", {31'd0, obs_lsu}, 32'd0);
        check("midreset_rf_we", {31'd0, rf_we}, 32'd0);
        // Counter cleared: four LSU wins again before the ALU.
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 1'b1, 5'd13, 32'hBEEF, 1'b1, 5'd14, 32'h100 + 32'(i));
            check("post_reset_pattern", {31'd0, obs_alu}, {31'd0, i == 4});
        end
        idle();

        // Streaming: eight back-to-back ALU writes.
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 1'b1, 5'(i + 1), 32'h5000 + 32'(i), 1'b0, 5'd0, 32'd0);
            check("stream_we", {31'd0, rf_we}, 32'd1);
            check("stream_data", rf_wdata, 32'h5000 + 32'(i));
        end
        idle();

        // Randomized traffic; each requester holds its request until accepted.
        hav = 1'b0; hlv = 1'b0;
        ha = 5'd0; hd = 32'd0; hl = 5'd0; hm = 32'd0;
        for (int i = 0; i < 300; i++) begin
            if (!hav && ($urandom_range(0, 3) != 0)) begin
                hav = 1'b1; ha = 5'($urandom_range(0, 31)); hd = $urandom;
            end
            if (!hlv && ($urandom_range(0, 3) != 0)) begin
                hlv = 1'b1; hl = 5'($urandom_range(0, 31)); hm = $urandom;
            end
            do_cycle(($urandom_range(0, 49) == 0), hav, ha, hd, hlv, hl, hm);
            if (exp_alu) hav = 1'b0;
            if (exp_lsu) hlv = 1'b0;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
